// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM with programmable latency and FREEZE stall.
// Optional counters rd_count/wr_count/stall_count when DM_STATS_EN is defined.
module data_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemRead_fMEM,
  input  logic        MemWrite_fMEM,
  input  logic [31:0] data_address_fMEM,
  input  logic [31:0] data_write_fMEM,
  input  logic [1:0]  store_size,
  output logic [31:0] data_read_2MEM,
  output logic        FREEZE,
  output logic        misalign_err
`ifdef DM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] stall_count
`endif
);

  localparam bit LAT0 = (LATENCY == 0);
  localparam logic [3:0] BUSY_LAST =
    4'(LATENCY >= 2 ? LATENCY - 2 : 0);
  localparam int AW = ADDR_BITS + 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic          rd_q, wr_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic [31:0]   rdata_q;
  logic          mis_q;

  logic [31:0] mem [2**ADDR_BITS];

  logic                 req, live, commit;
  logic                 c_rd, c_wr, c_mis;
  logic [AW-1:0]        c_addr;
  logic [31:0]          c_data, c_lanes;
  logic [1:0]           c_size;
  logic [3:0]           c_be;
  logic [ADDR_BITS-1:0] c_idx;
  logic                 unused_addr;

  function automatic logic mis_f(
    input logic [1:0] off,
    input logic [1:0] sz
  );
    unique case (sz)
      2'b01:   mis_f = off[0];
      2'b10:   mis_f = 1'b0;
      default: mis_f = (off != 2'b00);
    endcase
  endfunction

  // be[3] is the lane at [31:24], i.e. byte offset 0 (big-endian)
  function automatic logic [3:0] be_f(
    input logic [1:0] off,
    input logic [1:0] sz
  );
    if (mis_f(off, sz)) begin
      be_f = 4'b0000;
    end else begin
      unique case (sz)
        2'b01:   be_f = off[1] ? 4'b0011 : 4'b1100;
        2'b10:   be_f = 4'b1000 >> off;
        default: be_f = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [31:0] lanes_f(
    input logic [31:0] d,
    input logic [1:0]  sz
  );
    unique case (sz)
      2'b01:   lanes_f = {2{d[15:0]}};
      2'b10:   lanes_f = {4{d[7:0]}};
      default: lanes_f = d;
    endcase
  endfunction

  assign req  = MemRead_fMEM | MemWrite_fMEM;
  assign live = (state_q == IDLE);

  // In IDLE the request is taken straight from the pins; later from the latch
  assign c_rd   = live ? MemRead_fMEM : rd_q;
  assign c_wr   = live ? MemWrite_fMEM : wr_q;
  assign c_addr = live ? data_address_fMEM[AW-1:0] : addr_q;
  assign c_data = live ? data_write_fMEM : wdata_q;
  assign c_size = live ? store_size : size_q;

  assign c_idx   = c_addr[AW-1:2];
  assign c_mis   = mis_f(c_addr[1:0], c_size);
  assign c_be    = be_f(c_addr[1:0], c_size);
  assign c_lanes = lanes_f(c_data, c_size);

  assign commit = LAT0
    ? req
    : ((live && req && (LATENCY == 1)) ||
       (state_q == BUSY && cnt_q == BUSY_LAST));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req && !LAT0) begin
          if (LATENCY == 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'd0;
          end
        end
      end
      BUSY: begin
        if (cnt_q == BUSY_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= commit & c_mis;
      if (commit) rdata_q <= mem[c_idx];
      if (live && req) begin
        rd_q    <= MemRead_fMEM;
        wr_q    <= MemWrite_fMEM;
        addr_q  <= data_address_fMEM[AW-1:0];
        wdata_q <= data_write_fMEM;
        size_q  <= store_size;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && commit && c_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_lanes[8*i +: 8];
      end
    end
  end

  assign FREEZE =
    !LAT0 && ((live && req) || state_q == BUSY);
  assign data_read_2MEM = LAT0 ? mem[c_idx] : rdata_q;
  assign misalign_err   = LAT0 ? (req & c_mis) : mis_q;

  assign unused_addr = ^data_address_fMEM[31:AW];

`ifdef DM_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rd_count    <= 32'd0;
      wr_count    <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (commit && c_rd && !c_wr) rd_count <= rd_count + 32'd1;
      if (commit && c_wr) wr_count <= wr_count + 32'd1;
      if (FREEZE) stall_count <= stall_count + 32'd1;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = c_rd;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder against a byte-addressed model.
// Counter checks are compiled in when DM_STATS_EN is defined.
module tb_data_mem_responder;
  localparam int AB  = 10;
  localparam int LAT = 2;
  localparam int NB  = 4 << AB;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        MemRead_fMEM = 1'b0;
  logic        MemWrite_fMEM = 1'b0;
  logic [31:0] data_address_fMEM = '0;
  logic [31:0] data_write_fMEM = '0;
  logic [1:0]  store_size = '0;
  logic [31:0] data_read_2MEM;
  logic        FREEZE;
  logic        misalign_err;
`ifdef DM_STATS_EN
  logic [31:0] rd_count, wr_count, stall_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        known;
    logic        mis;
  } exp_t;

  exp_t q[$];
  logic [7:0] bmem [NB];
  bit         bknown [NB];

  always #5 CLK = ~CLK;

  data_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .MemRead_fMEM(MemRead_fMEM),
    .MemWrite_fMEM(MemWrite_fMEM),
    .data_address_fMEM(data_address_fMEM),
    .data_write_fMEM(data_write_fMEM),
    .store_size(store_size),
    .data_read_2MEM(data_read_2MEM),
    .FREEZE(FREEZE),
    .misalign_err(misalign_err)
`ifdef DM_STATS_EN
    ,
    .rd_count(rd_count),
    .wr_count(wr_count),
    .stall_count(stall_count)
`endif
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory seen as bytes; a word is four consecutive bytes, MSB first
  task automatic model(input logic wr,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0] sz,
                       output exp_t e);
    int ba, base, n;
    ba   = int'(a[AB+1:0]);
    base = ba - (ba % 4);
    e.data  = {bmem[base], bmem[base+1],
               bmem[base+2], bmem[base+3]};
    e.known = bknown[base] && bknown[base+1] &&
              bknown[base+2] && bknown[base+3];
    n = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
    e.mis = ((ba % n) != 0);
    if (wr && !e.mis) begin
      for (int k = 0; k < n; k++) begin
        bmem[ba+k]   = d[8*(n-1-k) +: 8];
        bknown[ba+k] = 1'b1;
      end
    end
  endtask

  task automatic do_req(input logic rd,
                        input logic wr,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [1:0] sz);
    exp_t e;
    int n;
    model(wr, a, d, sz, e);
    q.push_back(e);
    MemRead_fMEM      = rd;
    MemWrite_fMEM     = wr;
    data_address_fMEM = a;
    data_write_fMEM   = d;
    store_size        = sz;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (FREEZE && n < 64);
    if (FREEZE) begin
      checks++;
      errors++;
      $display("FAIL timeout freeze stuck addr=%h", a);
    end
    @(posedge CLK);
    #1;
    MemRead_fMEM  = 1'b0;
    MemWrite_fMEM = 1'b0;
  endtask

  // Monitor: a request seen with FREEZE low is the completion cycle
  initial begin
    int   stall;
    exp_t e;
    stall = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        stall = 0;
      end else if (FREEZE) begin
        stall++;
        check("mis_busy", 32'(misalign_err), 32'd0);
      end else if (MemRead_fMEM || MemWrite_fMEM) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected completion actual=1 required=0");
        end else begin
          e = q.pop_front();
          if (e.known) check("rdata", data_read_2MEM, e.data);
          check("misalign", 32'(misalign_err), 32'(e.mis));
          check("stall", 32'(stall), 32'(LAT));
        end
        stall = 0;
      end else begin
        check("mis_idle", 32'(misalign_err), 32'd0);
      end
    end
  end

  initial begin
    logic        rd, wr;
    logic [31:0] a;
    for (int i = 0; i < NB; i++) bknown[i] = 1'b0;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_freeze", 32'(FREEZE), 32'd0);
    check("rst_rdata", data_read_2MEM, 32'd0);
    check("rst_mis", 32'(misalign_err), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;

    do_req(0, 1, 32'h10, 32'hDEADBEEF, 2'b00);
    do_req(1, 0, 32'h10, 32'h0, 2'b00);
    do_req(0, 1, 32'h10, 32'h11223344, 2'b00);
    do_req(0, 1, 32'h11, 32'h000000AA, 2'b10);
    do_req(1, 0, 32'h10, 32'h0, 2'b00);
    do_req(0, 1, 32'h12, 32'h0000BEEF, 2'b01);
    do_req(1, 0, 32'h10, 32'h0, 2'b00);
    do_req(0, 1, 32'h13, 32'h00000055, 2'b00);
    do_req(1, 0, 32'h10, 32'h0, 2'b00);
    do_req(1, 0, 32'h11, 32'h0, 2'b00);
    do_req(0, 1, 32'h20, 32'h12345678, 2'b00);

    // Store aborted by reset while busy must not land
    MemWrite_fMEM     = 1'b1;
    data_address_fMEM = 32'h20;
    data_write_fMEM   = 32'h1;
    store_size        = 2'b00;
    @(posedge CLK);
    #1;
    RESET         = 1'b0;
    MemWrite_fMEM = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_freeze", 32'(FREEZE), 32'd0);
    check("abort_rdata", data_read_2MEM, 32'd0);
    check("abort_mis", 32'(misalign_err), 32'd0);
    @(posedge CLK);
    #1;
    do_req(1, 0, 32'h20, 32'h0, 2'b00);

    do_req(0, 1, 32'h1000, 32'h77, 2'b00);
    do_req(1, 0, 32'h0, 32'h0, 2'b00);
    do_req(1, 1, 32'h0, 32'hCAFEF00D, 2'b00);
    do_req(1, 0, 32'h0, 32'h0, 2'b00);

    for (int w = 0; w < 32; w++) begin
      do_req(0, 1, 32'(w * 4), $urandom, 2'b00);
    end

    for (int i = 0; i < 300; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = ($urandom & 32'hFFFF_F000) |
           32'($urandom_range(0, 31) << 2) |
           32'($urandom_range(0, 3));
      do_req(rd, wr, a, $urandom, 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 1)) @(posedge CLK);
      #1;
    end

`ifdef DM_STATS_EN
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    do_req(1, 0, 32'h10, 32'h0, 2'b00);
    do_req(1, 0, 32'h14, 32'h0, 2'b00);
    do_req(0, 1, 32'h18, 32'h9, 2'b00);
    @(negedge CLK);
    check("rd_count", rd_count, 32'd2);
    check("wr_count", wr_count, 32'd1);
    check("stall_count", stall_count, 32'(3 * LAT));
`endif

    @(negedge CLK);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
